// File: rtl/input_row_packer.sv
// Packs narrow input beats into full memory rows and writes each completed row
// to consecutive addresses, starting at row 0, until the requested row count is reached.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; counters and outputs quiet
// FILL  | s_ready high; accepted beats are stored in the row buffer
// WRITE | single-cycle memory write of the completed row buffer
// DONE  | single-cycle done pulse, then back to IDLE
module input_row_packer #(
  parameter int ARRAY_SIZE = 64,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int IN_WORDS   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH:0]              num_rows,
  input  logic                             s_valid,
  input  logic [IN_WORDS*DATA_WIDTH-1:0]   s_data,
  output logic                             s_ready,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] mem_din,
  output logic                             busy,
  output logic                             done
);

  localparam int BEATS   = ARRAY_SIZE / IN_WORDS;
  localparam int IN_BITS = IN_WORDS * DATA_WIDTH;
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                          state_q;
  state_t                          state_d;
  logic [ADDR_WIDTH-1:0]           row_q;
  logic [BW-1:0]                   beat_q;
  logic [ADDR_WIDTH:0]             num_rows_q;
  logic [ADDR_WIDTH:0]             rows_m1;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_buf;
  logic                            last_row;

  assign rows_m1  = num_rows_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_row = ({1'b0, row_q} == rows_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_rows == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        s_ready = 1'b1;
        if (s_valid && (beat_q == LAST_BEAT)) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = last_row ? DONE : FILL;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, captured row count and row buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      beat_q     <= '0;
      num_rows_q <= '0;
      row_buf    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (num_rows != '0)) begin
            num_rows_q <= num_rows;
            row_q      <= '0;
            beat_q     <= '0;
          end
        end
        FILL: begin
          if (s_valid) begin
            for (int k = 0; k < BEATS; k++) begin
              if (beat_q == BW'(k)) begin
                row_buf[k*IN_BITS +: IN_BITS] <= s_data;
              end
            end
            beat_q <= (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
          end
        end
        WRITE: begin
          if (!last_row) begin
            row_q <= row_q + ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Address and data are only presented during the write cycle
  assign mem_addr = (state_q == WRITE) ? row_q : '0;
  assign mem_din  = (state_q == WRITE) ? row_buf : '0;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_input_row_packer.sv
// Directed bench for input_row_packer: a table of load scenarios with hand-computed
// cycle counts, plus reset-abort and idle sequences.
module tb_input_row_packer;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int IB = 64;
  localparam int RB = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_rows = '0;
  logic          s_valid = 1'b0;
  logic [IB-1:0] s_data = '0;
  logic          s_ready, mem_en, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [RB-1:0] mem_din;

  input_row_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] w_addr[$];
  logic [RB-1:0] w_data[$];
  int            w_cyc[$];
  int            d_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 64; i++) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s: word %0d got %0h expected %0h", name, i, act[i*DW +: DW], exp[i*DW +: DW]);
          break;
        end
      end
    end
  endtask

  // Monitor: records writes and done pulses, checks cycle-level invariants
  always @(negedge clk) begin
    if (mem_we) begin
      w_addr.push_back(mem_addr);
      w_data.push_back(mem_din);
      w_cyc.push_back(cyc);
    end
    if (done) d_cyc.push_back(cyc);
    if (mem_en !== mem_we) chk("en_eq_we", {63'd0, mem_en}, {63'd0, mem_we});
    if (mem_we && s_ready) chk("ready_in_write", {63'd0, s_ready}, 64'd0);
    if (done && !busy) chk("busy_in_done", {63'd0, busy}, 64'd1);
  end

  function automatic logic [IB-1:0] beat_word(input int seed, input int b);
    logic [IB-1:0] v;
    for (int j = 0; j < 4; j++) v[j*DW +: DW] = 16'(seed + b*4 + j);
    return v;
  endfunction

  function automatic logic [RB-1:0] exp_row(input int seed, input int r);
    logic [RB-1:0] v;
    for (int i = 0; i < 64; i++) v[i*DW +: DW] = 16'(seed + r*64 + i);
    return v;
  endfunction

  task automatic clear_mon();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    d_cyc.delete();
  endtask

  task automatic run_load(input int nrows, input int stall_at, input int stall_len,
                          input int poke_at, input int seed, input int abort_after,
                          output int st);
    int  b, srem, budget, total;
    logic acc, stalled, poked;
    clear_mon();
    start = 1'b1;
    num_rows = 7'(nrows);
    @(posedge clk); #1;
    start = 1'b0;
    st = cyc;
    total = nrows * 16;
    b = 0; srem = stall_len; budget = 0; poked = 1'b0;
    while (b < total && budget < 3000) begin
      if (b == abort_after) return;
      if (b == poke_at && !poked) begin
        start = 1'b1;
        num_rows = 7'd5;
        poked = 1'b1;
      end
      if (b == stall_at && srem > 0) begin
        s_valid = 1'b0;
        s_data = {2{32'hDEADBEEF}};
        srem--;
        stalled = 1'b1;
      end else begin
        s_valid = 1'b1;
        s_data = beat_word(seed, b);
        stalled = 1'b0;
      end
      @(negedge clk);
      acc = s_valid & s_ready;
      if (stalled) chk("stall_ready", {63'd0, s_ready}, 64'd1);
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) b++;
      budget++;
    end
    if (budget >= 3000) chk("beat_budget", 64'(b), 64'(total));
    s_valid = 1'b0;
    s_data = {2{32'hDEADBEEF}};
    for (int i = 0; i < 60 && d_cyc.size() == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_load(input int nrows, input int stall_at, input int stall_len,
                            input int seed, input int exp_cyc, input int st);
    int extra;
    chk("n_writes", 64'(w_addr.size()), 64'(nrows));
    for (int r = 0; r < nrows && r < w_addr.size(); r++) begin
      extra = (stall_at >= 0 && stall_at / 16 <= r) ? stall_len : 0;
      chk($sformatf("addr_r%0d", r), 64'(w_addr[r]), 64'(r));
      chk($sformatf("wcyc_r%0d", r), 64'(w_cyc[r] - st), 64'(17*r + 16 + extra));
      chk_row($sformatf("data_r%0d", r), w_data[r], exp_row(seed, r));
    end
    chk("n_done", 64'(d_cyc.size()), 64'd1);
    if (d_cyc.size() > 0) chk("done_cyc", 64'(d_cyc[0] - st), 64'(exp_cyc));
    chk("busy_after", {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},  {63'd0, s_ready}, 64'd0);
    chk({tag, "_mem_en"},   {63'd0, mem_en}, 64'd0);
    chk({tag, "_mem_we"},   {63'd0, mem_we}, 64'd0);
    chk({tag, "_busy"},     {63'd0, busy}, 64'd0);
    chk({tag, "_done"},     {63'd0, done}, 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk_row({tag, "_mem_din"}, mem_din, '0);
  endtask

  typedef struct {
    int nrows;
    int stall_at;
    int stall_len;
    int poke_at;
    int seed;
    int exp_cyc;
  } vec_t;

  vec_t vecs[6];
  int st;

  initial begin
    vecs[0] = '{1,  -1, 0, -1, 0,    17};
    vecs[1] = '{2,   6, 5, -1, 1000, 39};
    vecs[2] = '{2,  -1, 0, 10, 2000, 34};
    vecs[3] = '{0,  -1, 0, -1, 0,    0};
    vecs[4] = '{3,  20, 2, -1, 3000, 53};
    vecs[5] = '{64, -1, 0, -1, 4000, 1088};

    #3;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Beats offered while idle must not be accepted
    s_valid = 1'b1;
    s_data = {2{32'h12345678}};
    clear_mon();
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", {63'd0, s_ready}, 64'd0);
    end
    chk("idle_writes", 64'(w_addr.size()), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_load(vecs[v].nrows, vecs[v].stall_at, vecs[v].stall_len,
               vecs[v].poke_at, vecs[v].seed, -1, st);
      check_load(vecs[v].nrows, vecs[v].stall_at, vecs[v].stall_len,
                 vecs[v].seed, vecs[v].exp_cyc, st);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset after 8 beats of row 3 aborts the load
    run_load(4, -1, 0, -1, 100, 56, st);
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    chk("abort_writes", 64'(w_addr.size()), 64'd3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_abort_writes", 64'(w_addr.size()), 64'd3);
    for (int i = 0; i < w_addr.size(); i++) chk("abort_addr", 64'(w_addr[i]), 64'(i));
    chk("post_abort_busy", {63'd0, busy}, 64'd0);
    chk("post_abort_ready", {63'd0, s_ready}, 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;

    run_load(1, -1, 0, -1, 500, -1, st);
    check_load(1, -1, 0, 500, 17, st);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
